// File: rtl/inport_buffer_pkg.sv
// Shared CPU datapath constants used by the input-port front end.
package inport_buffer_pkg;
  localparam int WORD_W = 32;
endpackage

// File: rtl/inport_buffer.sv
// Input-port FIFO: device words are visible on InPortData 1 cycle after push, and the next word appears right after the pop edge.
// dev_ready drops only when DEPTH words are held; a same-cycle pop does not admit a push while full.
module inport_buffer
  import inport_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = WORD_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         dev_data,
  input  logic                     dev_valid,
  output logic                     dev_ready,
  input  logic                     InPortIn,
  output logic [WIDTH-1:0]         InPortData,
  output logic                     in_empty,
  output logic [$clog2(DEPTH):0]   in_count,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             underflow_q, underflow_d;
  logic             push, pop;

  assign dev_ready  = (count_q != FULL_CNT);
  assign in_empty   = (count_q == '0);
  assign in_count   = count_q;
  assign underflow  = underflow_q;
  assign InPortData = in_empty ? '0 : mem_q[rd_ptr_q];

  assign push = dev_valid && dev_ready && !reset;
  assign pop  = InPortIn && !in_empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A strobe on an empty queue is recorded even if a push lands this cycle.
    if (InPortIn && in_empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= dev_data;
  end

endmodule
